// File: rtl/fp_agg_scheduler.sv
// fp_agg_scheduler: gathers one operand from each of four worker lanes and
// issues the aligned set to a 4-input adder tree as a one-cycle beat, gated by
// result-FIFO credits, then drains the tree and reports job completion.
module fp_agg_scheduler #(
    parameter int FP_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     num_elems,
    output logic                     busy,
    output logic                     done,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_0_tdata,
    input  logic                     S_AXIS_0_tvalid,
    output logic                     S_AXIS_0_tready,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_1_tdata,
    input  logic                     S_AXIS_1_tvalid,
    output logic                     S_AXIS_1_tready,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_2_tdata,
    input  logic                     S_AXIS_2_tvalid,
    output logic                     S_AXIS_2_tready,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_3_tdata,
    input  logic                     S_AXIS_3_tvalid,
    output logic                     S_AXIS_3_tready,
    output logic [FP_DATA_WIDTH-1:0] M_AXIS_0_tdata,
    output logic                     M_AXIS_0_tvalid,
    output logic [FP_DATA_WIDTH-1:0] M_AXIS_1_tdata,
    output logic                     M_AXIS_1_tvalid,
    output logic [FP_DATA_WIDTH-1:0] M_AXIS_2_tdata,
    output logic                     M_AXIS_2_tvalid,
    output logic [FP_DATA_WIDTH-1:0] M_AXIS_3_tdata,
    output logic                     M_AXIS_3_tvalid,
    input  logic                     result_valid,
    input  logic                     fifo_rd_en,
    input  logic                     fifo_empty,
    output logic [CNT_WIDTH-1:0]     issue_count,
    output logic                     credit_err
);

    localparam int CRW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CRW-1:0]           CREDIT_MAX  = CRW'(FIFO_DEPTH);
    localparam logic [CRW-1:0]           CREDIT_ONE  = CRW'(1);
    localparam logic [CRW-1:0]           CREDIT_ZERO = CRW'(0);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ZERO    = CNT_WIDTH'(0);
    localparam logic [FP_DATA_WIDTH-1:0] DATA_ZERO   = FP_DATA_WIDTH'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     num_q, num_d;
    logic [CNT_WIDTH-1:0]     issue_count_q, issue_count_d;
    logic [CNT_WIDTH-1:0]     inflight_q, inflight_d;
    logic [CRW-1:0]           credit_q, credit_d;
    logic                     credit_err_q, credit_err_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     m_valid_q, m_valid_d;
    logic [FP_DATA_WIDTH-1:0] m_data_q [4];
    logic [FP_DATA_WIDTH-1:0] m_data_d [4];
    logic [3:0]               hold_vld_q, hold_vld_d;
    logic [FP_DATA_WIDTH-1:0] hold_data_q [4];
    logic [FP_DATA_WIDTH-1:0] hold_data_d [4];
    logic [CNT_WIDTH-1:0]     acc_q [4];
    logic [CNT_WIDTH-1:0]     acc_d [4];

    logic [FP_DATA_WIDTH-1:0] s_tdata [4];
    logic [3:0]               s_tvalid;
    logic [3:0]               s_tready;
    logic                     fire;
    logic                     start_acc;
    logic                     pop;

    assign s_tdata[0] = S_AXIS_0_tdata;
    assign s_tdata[1] = S_AXIS_1_tdata;
    assign s_tdata[2] = S_AXIS_2_tdata;
    assign s_tdata[3] = S_AXIS_3_tdata;
    assign s_tvalid   = {S_AXIS_3_tvalid, S_AXIS_2_tvalid, S_AXIS_1_tvalid, S_AXIS_0_tvalid};

    // A set issues only when every lane holds an operand and the FIFO has room.
    assign fire      = (state_q == ST_RUN) && (&hold_vld_q) && (credit_q != CREDIT_ZERO);
    assign start_acc = (state_q == ST_IDLE) && start;
    assign pop       = fifo_rd_en && !fifo_empty;

    // Lane ready: a hold slot is free now or is being emptied by this cycle's fire.
    always_comb begin
        s_tready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            s_tready[k] = (state_q == ST_RUN) && (acc_q[k] < num_q) && (!hold_vld_q[k] || fire);
        end
    end

    // Hold registers and per-lane accept counters.
    always_comb begin
        hold_vld_d = hold_vld_q;
        for (int k = 0; k < 4; k++) begin
            hold_data_d[k] = hold_data_q[k];
            acc_d[k]       = acc_q[k];
            if (start_acc) begin
                hold_vld_d[k] = 1'b0;
                acc_d[k]      = CNT_ZERO;
            end else if (s_tvalid[k] && s_tready[k]) begin
                hold_vld_d[k]  = 1'b1;
                hold_data_d[k] = s_tdata[k];
                acc_d[k]       = acc_q[k] + CNT_ONE;
            end else if (fire) begin
                hold_vld_d[k] = 1'b0;
            end else begin
                hold_vld_d[k] = hold_vld_q[k];
            end
        end
    end

    // Job FSM, issue beat, credit and in-flight bookkeeping.
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        done_d        = 1'b0;
        m_valid_d     = fire;
        credit_d      = credit_q;
        credit_err_d  = credit_err_q;
        inflight_d    = inflight_q;
        issue_count_d = fire ? (issue_count_q + CNT_ONE) : issue_count_q;
        for (int k = 0; k < 4; k++) begin
            m_data_d[k] = fire ? hold_data_q[k] : m_data_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d         = num_elems;
                    issue_count_d = CNT_ZERO;
                    if (num_elems != CNT_ZERO) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_count_d == num_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == CNT_ZERO) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pop beyond the FIFO depth means the consumer read a slot we never
        // filled; keep the credit pinned and flag it.
        case ({fire, pop})
            2'b10: credit_d = credit_q - CREDIT_ONE;
            2'b01: begin
                if (credit_q == CREDIT_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CREDIT_ONE;
                end
            end
            default: credit_d = credit_q;
        endcase

        case ({fire, result_valid})
            2'b10: inflight_d = inflight_q + CNT_ONE;
            2'b01: begin
                if (inflight_q != CNT_ZERO) begin
                    inflight_d = inflight_q - CNT_ONE;
                end else begin
                    inflight_d = inflight_q;
                end
            end
            default: inflight_d = inflight_q;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q       <= ST_IDLE;
            num_q         <= CNT_ZERO;
            issue_count_q <= CNT_ZERO;
            inflight_q    <= CNT_ZERO;
            credit_q      <= CREDIT_MAX;
            credit_err_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            m_valid_q     <= 1'b0;
            hold_vld_q    <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                m_data_q[k]    <= DATA_ZERO;
                hold_data_q[k] <= DATA_ZERO;
                acc_q[k]       <= CNT_ZERO;
            end
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            issue_count_q <= issue_count_d;
            inflight_q    <= inflight_d;
            credit_q      <= credit_d;
            credit_err_q  <= credit_err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            m_valid_q     <= m_valid_d;
            hold_vld_q    <= hold_vld_d;
            for (int k = 0; k < 4; k++) begin
                m_data_q[k]    <= m_data_d[k];
                hold_data_q[k] <= hold_data_d[k];
                acc_q[k]       <= acc_d[k];
            end
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign issue_count     = issue_count_q;
    assign credit_err      = credit_err_q;
    assign S_AXIS_0_tready = s_tready[0];
    assign S_AXIS_1_tready = s_tready[1];
    assign S_AXIS_2_tready = s_tready[2];
    assign S_AXIS_3_tready = s_tready[3];
    assign M_AXIS_0_tvalid = m_valid_q;
    assign M_AXIS_1_tvalid = m_valid_q;
    assign M_AXIS_2_tvalid = m_valid_q;
    assign M_AXIS_3_tvalid = m_valid_q;
    assign M_AXIS_0_tdata  = m_data_q[0];
    assign M_AXIS_1_tdata  = m_data_q[1];
    assign M_AXIS_2_tdata  = m_data_q[2];
    assign M_AXIS_3_tdata  = m_data_q[3];

endmodule

// File: tb/tb_fp_agg_scheduler.sv
// Testbench for fp_agg_scheduler: directed scenarios plus randomized jobs,
// checked every cycle against a queue-based reference model of the scheduler.
module tb_fp_agg_scheduler;

    logic        aclk = 1'b0;
    logic        srst;
    logic        start;
    logic [15:0] num_elems;
    logic        busy, done, credit_err;
    logic [15:0] issue_count;
    logic [31:0] s_tdata [4];
    logic        s_tvalid [4];
    logic        s_tready [4];
    logic [31:0] m_tdata [4];
    logic        m_tvalid [4];
    logic        result_valid, fifo_rd_en, fifo_empty;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_state;      // 0 idle, 1 run, 2 drain
    int          m_num, m_credit, m_inflight, m_issue;
    bit          m_err, exp_mvalid, exp_done, exp_busy;
    int          m_acc [4];
    logic [31:0] lq [4][$];
    logic [31:0] exp_mdata [4];

    // stimulus controls
    int  lane_mode [4];        // 0 idle, 1 always valid, 2 random valid
    bit  auto_rv = 1'b1;
    int  rv_pct = 50;
    bit  rand_pop = 1'b0;
    bit  rand_start = 1'b0;
    int  tree_cnt = 0;
    int  beats, done_cnt, cyc;
    bit  saw_done;
    int  beat_cyc [$];

    always #5 aclk = ~aclk;

    fp_agg_scheduler #(.FP_DATA_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(16)) dut (
        .aclk(aclk), .srst(srst), .start(start), .num_elems(num_elems),
        .busy(busy), .done(done),
        .S_AXIS_0_tdata(s_tdata[0]), .S_AXIS_0_tvalid(s_tvalid[0]), .S_AXIS_0_tready(s_tready[0]),
        .S_AXIS_1_tdata(s_tdata[1]), .S_AXIS_1_tvalid(s_tvalid[1]), .S_AXIS_1_tready(s_tready[1]),
        .S_AXIS_2_tdata(s_tdata[2]), .S_AXIS_2_tvalid(s_tvalid[2]), .S_AXIS_2_tready(s_tready[2]),
        .S_AXIS_3_tdata(s_tdata[3]), .S_AXIS_3_tvalid(s_tvalid[3]), .S_AXIS_3_tready(s_tready[3]),
        .M_AXIS_0_tdata(m_tdata[0]), .M_AXIS_0_tvalid(m_tvalid[0]),
        .M_AXIS_1_tdata(m_tdata[1]), .M_AXIS_1_tvalid(m_tvalid[1]),
        .M_AXIS_2_tdata(m_tdata[2]), .M_AXIS_2_tvalid(m_tvalid[2]),
        .M_AXIS_3_tdata(m_tdata[3]), .M_AXIS_3_tvalid(m_tvalid[3]),
        .result_valid(result_valid), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
        .issue_count(issue_count), .credit_err(credit_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_num = 0; m_credit = 8; m_inflight = 0; m_issue = 0;
        m_err = 1'b0; exp_mvalid = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
        tree_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            lq[k].delete();
            exp_mdata[k] = 32'h0;
        end
    endtask

    // One clock: drive inputs, compare at negedge, advance the model.
    task automatic cycle();
        bit fire, pop;
        bit tr [4];
        int infl_prev;
        for (int k = 0; k < 4; k++) begin
            s_tvalid[k] = (lane_mode[k] == 1) ? 1'b1 :
                          (lane_mode[k] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_tdata[k]  = $urandom();
        end
        if (auto_rv) result_valid = (tree_cnt > 0) && ($urandom_range(0, 99) < rv_pct);
        if (rand_pop) begin
            fifo_rd_en = 1'($urandom_range(0, 1));
            fifo_empty = ($urandom_range(0, 3) == 0);
        end
        if (rand_start && !start && ($urandom_range(0, 15) == 0)) begin
            start = 1'b1;
            num_elems = 16'($urandom_range(0, 6));
        end
        @(negedge aclk);
        fire = (m_state == 1) && (lq[0].size() > 0) && (lq[1].size() > 0) &&
               (lq[2].size() > 0) && (lq[3].size() > 0) && (m_credit > 0);
        for (int k = 0; k < 4; k++) begin
            tr[k] = (m_state == 1) && (m_acc[k] < m_num) && ((lq[k].size() == 0) || fire);
            chk($sformatf("tready%0d", k), s_tready[k], tr[k]);
            chk($sformatf("mvalid%0d", k), m_tvalid[k], exp_mvalid);
            if (exp_mvalid) chk($sformatf("mdata%0d", k), m_tdata[k], exp_mdata[k]);
        end
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("issue_count", issue_count, 32'(m_issue));
        chk("credit_err", credit_err, m_err);
        if (m_tvalid[0] === 1'b1) begin
            beats++;
            beat_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            saw_done = 1'b1;
        end
        tree_cnt = tree_cnt + ((m_tvalid[0] === 1'b1) ? 1 : 0) - (result_valid ? 1 : 0);
        // advance model
        pop = fifo_rd_en && !fifo_empty;
        infl_prev = m_inflight;
        exp_mvalid = fire;
        if (fire) for (int k = 0; k < 4; k++) exp_mdata[k] = lq[k].pop_front();
        for (int k = 0; k < 4; k++) begin
            if (s_tvalid[k] && tr[k]) begin
                lq[k].push_back(s_tdata[k]);
                m_acc[k]++;
            end
        end
        if (fire && !pop) m_credit--;
        else if (pop && !fire) begin
            if (m_credit == 8) m_err = 1'b1;
            else m_credit++;
        end
        if (fire && !result_valid) m_inflight++;
        else if (result_valid && !fire && m_inflight > 0) m_inflight--;
        if (fire) m_issue++;
        exp_done = 1'b0;
        if (m_state == 0) begin
            if (start) begin
                m_num = num_elems;
                m_issue = 0;
                for (int k = 0; k < 4; k++) m_acc[k] = 0;
                if (num_elems != 0) m_state = 1;
                else exp_done = 1'b1;
            end
        end else if (m_state == 1) begin
            if (m_issue == m_num) m_state = 2;
        end else begin
            if (infl_prev == 0) begin
                exp_done = 1'b1;
                m_state = 0;
            end
        end
        if (srst) model_reset();
        exp_busy = (m_state != 0);
        @(posedge aclk);
        #1;
        cyc++;
        start = 1'b0;
        srst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        saw_done = 1'b0;
        while (!saw_done && n < budget) begin
            cycle();
            n++;
        end
        chk("done_timeout", saw_done, 1'b1);
    endtask

    task automatic set_modes(input int a, input int b, input int c, input int d);
        lane_mode[0] = a; lane_mode[1] = b; lane_mode[2] = c; lane_mode[3] = d;
    endtask

    initial begin
        int n;
        srst = 1'b1; start = 1'b0; num_elems = 16'd0;
        result_valid = 1'b0; fifo_rd_en = 1'b0; fifo_empty = 1'b1;
        cyc = 0; beats = 0; done_cnt = 0; saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_tvalid[k] = 1'b0; s_tdata[k] = 32'h0; lane_mode[k] = 0;
        end
        repeat (2) @(posedge aclk);
        #1;
        srst = 1'b0;
        model_reset();
        // reset state
        for (int k = 0; k < 4; k++) begin
            chk("rst_tready", s_tready[k], 1'b0);
            chk("rst_mvalid", m_tvalid[k], 1'b0);
            chk("rst_mdata", m_tdata[k], 32'h0);
        end
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", credit_err, 1'b0);
        chk("rst_issue", issue_count, 32'h0);

        // 1: four elements, all lanes streaming, no reads
        set_modes(1, 1, 1, 1);
        beats = 0; done_cnt = 0; beat_cyc.delete();
        start = 1'b1; num_elems = 16'd4;
        cycle();
        wait_done(100);
        repeat (2) cycle();
        chk("t1_beats", beats, 4);
        chk("t1_done_once", done_cnt, 1);
        chk("t1_issue", issue_count, 32'd4);
        chk("t1_b2b", beat_cyc[3] - beat_cyc[0], 3);

        // 2: lane 2 late by five cycles
        set_modes(1, 1, 0, 1);
        beats = 0;
        start = 1'b1; num_elems = 16'd2;
        cycle();
        repeat (5) cycle();
        chk("t2_nofire", beats, 0);
        chk("t2_hold_tready0", s_tready[0], 1'b0);
        chk("t2_hold_tready3", s_tready[3], 1'b0);
        lane_mode[2] = 1;
        wait_done(100);
        chk("t2_beats", beats, 2);

        // pops on an empty FIFO are ignored, then refill credits to full
        set_modes(0, 0, 0, 0);
        fifo_rd_en = 1'b1; fifo_empty = 1'b1;
        repeat (3) cycle();
        fifo_empty = 1'b0;
        n = 0;
        while (m_credit < 8 && n < 20) begin cycle(); n++; end
        fifo_rd_en = 1'b0;
        chk("refill_err", credit_err, 1'b0);

        // 3: twelve elements, no reads -> stall after eight
        set_modes(1, 1, 1, 1);
        beats = 0; beat_cyc.delete();
        start = 1'b1; num_elems = 16'd12;
        cycle();
        repeat (40) cycle();
        chk("t3_beats8", beats, 8);
        chk("t3_issue8", issue_count, 32'd8);
        for (int k = 0; k < 4; k++) chk("t3_stall_tready", s_tready[k], 1'b0);
        chk("t3_busy", busy, 1'b1);
        fifo_rd_en = 1'b1; fifo_empty = 1'b0;
        cycle();
        fifo_rd_en = 1'b0;
        repeat (10) cycle();
        chk("t3_one_more", beats, 9);

        // 4: credit hovers at 1 with a pop every cycle -> back-to-back issue
        fifo_rd_en = 1'b1; fifo_empty = 1'b0;
        n = 0;
        while (beats < 12 && n < 30) begin cycle(); n++; end
        fifo_rd_en = 1'b0;
        chk("t4_beats", beats, 12);
        chk("t4_b2b", beat_cyc[11] - beat_cyc[9], 2);
        wait_done(100);

        // 5: overflow pops saturate and set the sticky error
        fifo_rd_en = 1'b1; fifo_empty = 1'b1;
        repeat (3) cycle();
        fifo_empty = 1'b0;
        n = 0;
        while (m_credit < 8 && n < 20) begin cycle(); n++; end
        repeat (2) cycle();
        fifo_rd_en = 1'b0;
        cycle();
        chk("t5_err", credit_err, 1'b1);
        repeat (3) cycle();
        chk("t5_err_sticky", credit_err, 1'b1);

        // 6: srst mid-job after three issues
        start = 1'b1; num_elems = 16'd10;
        cycle();
        n = 0;
        while (m_issue < 3 && n < 50) begin cycle(); n++; end
        done_cnt = 0;
        srst = 1'b1;
        cycle();
        chk("t6_busy", busy, 1'b0);
        chk("t6_mvalid", m_tvalid[0], 1'b0);
        chk("t6_err_clr", credit_err, 1'b0);
        chk("t6_issue", issue_count, 32'h0);
        for (int k = 0; k < 4; k++) chk("t6_tready", s_tready[k], 1'b0);
        repeat (3) cycle();
        chk("t6_no_done", done_cnt, 0);
        // credits restored: eight back-to-back issues without any read
        beats = 0; beat_cyc.delete();
        start = 1'b1; num_elems = 16'd8;
        cycle();
        wait_done(100);
        chk("t6_beats8", beats, 8);
        chk("t6_b2b8", beat_cyc[7] - beat_cyc[0], 7);

        // num_elems == 0: done one cycle later, never busy
        set_modes(0, 0, 0, 0);
        start = 1'b1; num_elems = 16'd0;
        cycle();
        chk("z_done", done, 1'b1);
        chk("z_busy", busy, 1'b0);
        cycle();
        chk("z_done_pulse", done, 1'b0);
        chk("z_busy2", busy, 1'b0);

        // randomized jobs with random lanes, pops, results and stray starts
        set_modes(2, 2, 2, 2);
        rand_pop = 1'b1;
        rand_start = 1'b1;
        for (int j = 0; j < 8; j++) begin
            start = 1'b1;
            num_elems = 16'($urandom_range(1, 10));
            cycle();
            wait_done(400);
        end
        rand_start = 1'b0;
        n = 0;
        while (exp_busy && n < 400) begin cycle(); n++; end
        chk("final_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_agg_scheduler.md
Name: fp_agg_scheduler

Overview:
- Sequences the 4-input floating-point adder tree: collects one operand from each of four AXI-Stream worker lanes and issues the aligned set to the tree as a single-cycle valid beat.
- Gates each issue on free space in the downstream result FIFO (credit scheme), so tree results are never dropped.
- Counts a configured number of elements per aggregation job, drains results still in the tree, then signals done.

Parameters:
- FP_DATA_WIDTH, 32, operand/result width.
- FIFO_DEPTH, 8, result FIFO entries; initial and maximum credit value.
- CNT_WIDTH, 16, width of element and issue counters.

Ports:
- aclk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- start  in  1  one-cycle job start pulse; sampled only in IDLE.
- num_elems  in  CNT_WIDTH  element count per lane for the job; latched on an accepted start.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at job completion.
- S_AXIS_k_tdata  in  FP_DATA_WIDTH  lane k operand, k=0..3.
- S_AXIS_k_tvalid  in  1  lane k valid.
- S_AXIS_k_tready  out  1  lane k ready.
- M_AXIS_k_tdata  out  FP_DATA_WIDTH  operand to adder tree input k.
- M_AXIS_k_tvalid  out  1  adder tree input k valid; identical for all k.
- result_valid  in  1  tree final-stage result valid (the FIFO write strobe).
- fifo_rd_en  in  1  consumer read of the result FIFO.
- fifo_empty  in  1  result FIFO empty.
- issue_count  out  CNT_WIDTH  sets issued in the current job.
- credit_err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset: state IDLE; all holds cleared; credit=FIFO_DEPTH; inflight=0; issue_count=0.
- Reset values of outputs: tready=0, M_AXIS_*_tvalid=0, M_AXIS_*_tdata=0, busy=0, done=0, credit_err=0.
- srst mid-job aborts the job with no done pulse. The result FIFO shares srst, so credits are restored to FIFO_DEPTH.
- States:
  - IDLE: start=1 latches num_elems and clears per-lane accept counters and issue_count.
    - num_elems!=0 -> RUN.
    - num_elems==0 -> done pulses next cycle, remain IDLE.
  - RUN: issue_count reaches num_elems -> DRAIN.
  - DRAIN: inflight==0 -> done=1 for one cycle, return to IDLE.
- start in RUN/DRAIN is ignored.
- Lane holds: each lane has a one-entry hold register plus an accept counter.
  - tready_k = (state==RUN) && (acc_k < num_elems) && (!hold_k || fire).
  - A lane may run ahead of the others by at most one element.
- fire = RUN && all four holds valid && credit != 0.
  - The cycle after fire: M_AXIS_k_tdata=hold_k data and all M_AXIS_k_tvalid=1 for exactly one cycle.
  - Each fire is one registered cycle of latency from the hold registers.
  - Back-to-back fires are allowed, giving one issue per cycle.
- fire clears all holds in the same cycle a new beat may be accepted into them.
- Credit:
  - −1 on fire; +1 on (fifo_rd_en && !fifo_empty).
  - Both in the same cycle: unchanged.
  - An increment that would exceed FIFO_DEPTH saturates and sets credit_err. credit_err clears only on srst.
- inflight: +1 on fire, −1 on result_valid; both in the same cycle: unchanged.
- Adder tree latency is opaque; completion is tracked by result_valid only.
- issue_count increments on fire and holds its value after done until the next accepted start.

Test Plan:
- Start with num_elems=4, all lanes valid every cycle, no reads, FIFO_DEPTH=8 -> four consecutive M_AXIS valid beats; credit 8→4; DRAIN until 4 result_valid pulses; done pulses once; issue_count=4.
- Lane 2 tvalid delayed 5 cycles, others valid -> lanes 0, 1, 3 hold one beat with tready=0; no fire until lane 2 arrives; issued data equals each lane's first beat.
- num_elems=12, no fifo_rd_en -> exactly 8 issues, then a stall with all tready=0. A single fifo_rd_en with fifo_empty=0 allows exactly one more issue.
- Simultaneous fire and valid pop each cycle at credit=1 -> credit stays 1; continuous issue.
- fifo_rd_en with fifo_empty=1 -> credit unchanged. Extra pops at credit=8 -> credit stays 8 and credit_err=1.
- srst asserted during RUN with 3 sets issued -> next cycle: IDLE, busy=0, credit=8, tready=0, M_AXIS valid=0, no done. num_elems=0 start -> done one cycle later, busy never asserts.
